// File: rtl/tile_router_v1_00_a_packet_scheduler.sv
// Packet-atomic round-robin flit scheduler with downstream credit tracking.
// Optional client-0 priority: define TILE_ROUTER_SCHED_PRIO0_EN.
module tile_router_v1_00_a_packet_scheduler #(
    parameter int C_NUM_CLIENTS = 8,
    parameter int C_CREDITS     = 8,
    localparam int SEL_W = (C_NUM_CLIENTS > 1) ? $clog2(C_NUM_CLIENTS) : 1,
    localparam int CNT_W = $clog2(C_CREDITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [C_NUM_CLIENTS-1:0] req_valid,
    input  logic [C_NUM_CLIENTS-1:0] req_last,
    output logic [C_NUM_CLIENTS-1:0] req_accept,
    output logic                     grant_valid,
    output logic [SEL_W-1:0]         grant_sel,
    output logic [C_NUM_CLIENTS-1:0] grant_oh,
    input  logic                     credit_return,
    output logic [CNT_W-1:0]         credit_count,
    output logic                     busy,
    output logic                     credit_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_owner;
    logic [SEL_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_credit_count;
    logic               r_credit_err;

    logic               w_has_credit;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_grant_valid;
    logic [SEL_W-1:0]   w_grant_sel;
    logic               w_tail;
    logic               w_prio_skip;

    function automatic logic [SEL_W-1:0] f_inc(input logic [SEL_W-1:0] v);
        return (int'(v) == C_NUM_CLIENTS - 1) ? '0 : v + SEL_W'(1);
    endfunction

    assign w_has_credit = (r_credit_count != '0);

    // First requester at or after rr_ptr, wrapping past the top client.
    always_comb begin
        int j;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        j          = 0;
        for (int k = 0; k < C_NUM_CLIENTS; k++) begin
            j = (int'(r_rr_ptr) + k) % C_NUM_CLIENTS;
            if (!w_rr_found && req_valid[j]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SEL_W'(j);
            end
        end
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_sel   = '0;
        if (!rst && w_has_credit) begin
            if (r_state == ST_LOCKED) begin
                if (req_valid[r_owner]) begin
                    w_grant_valid = 1'b1;
                    w_grant_sel   = r_owner;
                end
            end else begin
`ifdef TILE_ROUTER_SCHED_PRIO0_EN
                if (req_valid[0]) begin
                    w_grant_valid = 1'b1;
                    w_grant_sel   = '0;
                end else
`endif
                if (w_rr_found) begin
                    w_grant_valid = 1'b1;
                    w_grant_sel   = w_rr_idx;
                end
            end
        end
    end

    assign w_tail = w_grant_valid && req_last[w_grant_sel];

`ifdef TILE_ROUTER_SCHED_PRIO0_EN
    // Client-0 packets must not disturb the fairness pointer of the others.
    assign w_prio_skip = (w_grant_sel == '0);
`else
    assign w_prio_skip = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < C_NUM_CLIENTS; gi++) begin : g_oh
            assign grant_oh[gi] = w_grant_valid && (w_grant_sel == SEL_W'(gi));
        end
    endgenerate

    assign req_accept   = grant_oh;
    assign grant_valid  = w_grant_valid;
    assign grant_sel    = w_grant_sel;
    assign credit_count = r_credit_count;
    assign busy         = (r_state == ST_LOCKED);
    assign credit_err   = r_credit_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_owner        <= '0;
            r_rr_ptr       <= '0;
            r_credit_count <= CNT_W'(C_CREDITS);
            r_credit_err   <= 1'b0;
        end else begin
            case ({w_grant_valid, credit_return})
                2'b10: r_credit_count <= r_credit_count - CNT_W'(1);
                2'b01: begin
                    if (r_credit_count == CNT_W'(C_CREDITS))
                        r_credit_err <= 1'b1;
                    else
                        r_credit_count <= r_credit_count + CNT_W'(1);
                end
                default: ;
            endcase

            if (r_state == ST_IDLE && w_grant_valid) begin
                r_owner <= w_grant_sel;
                if (!req_last[w_grant_sel])
                    r_state <= ST_LOCKED;
            end

            if (w_tail) begin
                r_state <= ST_IDLE;
                if (!w_prio_skip)
                    r_rr_ptr <= f_inc(w_grant_sel);
            end
        end
    end

endmodule

// File: doc/tile_router_v1_00_a_packet_scheduler.md
TILE_ROUTER_V1_00_A_PACKET_SCHEDULER -- requirements
Module: tile_router_v1_00_a_packet_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- C_NUM_CLIENTS, 8, number of requesting clients.
- C_CREDITS, 8, downstream buffer entries (initial credit count).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock; all state changes on its rising edge.
- rst, in, 1, synchronous reset, active-high.
- req_valid, in, C_NUM_CLIENTS, client i has a flit.
- req_last, in, C_NUM_CLIENTS, client i flit is a packet tail.
- req_accept, out, C_NUM_CLIENTS, one-hot; flit of client i transferred this cycle.
- grant_valid, out, 1, a transfer occurs this cycle (OR of req_accept).
- grant_sel, out, clog2(C_NUM_CLIENTS), binary index of the granted client.
- grant_oh, out, C_NUM_CLIENTS, one-hot granted client (equals req_accept).
- credit_return, in, 1, downstream freed one entry.
- credit_count, out, clog2(C_CREDITS+1), credits currently available.
- busy, out, 1, packet lock held.
- credit_err, out, 1, sticky credit overflow flag.

Function
REQ-003 The block SHALL have two states: IDLE (no lock) and LOCKED (lock on owner index).
REQ-004 A transfer SHALL occur only when credit_count>0; req_accept, grant_* SHALL be combinational from registered state and current inputs (zero-cycle handshake).
REQ-005 In IDLE the grant SHALL go to the first requesting client at or after rr_ptr, searching upward with wrap from C_NUM_CLIENTS-1 to 0.
REQ-006 In IDLE, a granted flit with req_last=1 SHALL leave the state IDLE; with req_last=0 it SHALL enter LOCKED with owner=granted index.
REQ-007 In LOCKED only the owner SHALL be eligible; other requests SHALL receive no accept even if credits are available.
REQ-008 In LOCKED, an owner flit accepted with req_last=1 SHALL return to IDLE on the next edge.
REQ-009 On every packet completion (tail accepted) rr_ptr SHALL become (owner+1) mod C_NUM_CLIENTS.
REQ-010 In LOCKED with req_valid[owner]=0 the lock SHALL be held, with no grant.
REQ-011 busy SHALL equal 1 exactly in LOCKED.
REQ-012 credit_count SHALL decrement by 1 per transfer and increment by 1 per credit_return; simultaneous transfer and return SHALL leave it unchanged.
REQ-013 A credit_return at credit_count==C_CREDITS without a simultaneous transfer SHALL be dropped and SHALL set credit_err, which stays 1 until reset.
REQ-014 grant_sel SHALL be 0 and grant_oh all-zero whenever grant_valid=0.

Reset
REQ-015 On rst=1 at a clock edge:
- state=IDLE, rr_ptr=0, owner=0.
- credit_count=C_CREDITS.
- credit_err=0, busy=0.
REQ-016 During rst=1, req_accept, grant_valid, grant_oh and grant_sel SHALL be 0 regardless of inputs.
REQ-017 Reset asserted mid-packet SHALL abandon the lock; no partial-packet state survives.

Configuration
REQ-018 Macro TILE_ROUTER_SCHED_PRIO0_EN SHALL control client-0 priority.
- Defined: in IDLE, client 0 wins whenever req_valid[0]=1, regardless of rr_ptr; completion of a client-0 packet SHALL NOT update rr_ptr. LOCKED behaviour is unchanged, so client 0 cannot pre-empt another client's packet.
- Undefined: pure round-robin per REQ-005.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then all 8 clients request single-flit packets (last=1), credit_return=1 each cycle -> grants 0,1,2,...,7,0 on consecutive cycles.
- Client 2 sends a 3-flit packet while client 5 requests continuously -> accepts to 2,2,2; busy=1 for 2 cycles; then 5 is granted.
- Client 3 locked, req_valid[3] drops for 4 cycles, client 6 requesting -> no grants for 4 cycles, busy=1; client 3 resumes and completes.
- C_CREDITS=8, no credit_return, continuous requests -> 8 transfers, credit_count reaches 0, grants stop; one credit_return -> exactly one more transfer.
- credit_return with credit_count=8 and no transfer -> credit_count stays 8, credit_err=1 until rst.
- With TILE_ROUTER_SCHED_PRIO0_EN defined, clients 0 and 4 always requesting single-flit packets -> client 0 granted every IDLE cycle; rr_ptr stays unchanged.
